// File: rtl/booth16_seq_mantissa_mul.sv
// ---------------------------------------------------------------------------
// booth16_seq_mantissa_mul
//
// Iterative unsigned mantissa multiplier for the fp32 datapath. The
// multiplier operand is recoded into radix-16 Booth digits; one digit is
// retired per cycle and its partial product is folded into a carry-save
// accumulator (SUM/CARRY) by a 3:2 compressor. A single carry-propagate add
// resolves the product once all digits have been consumed.
//
// Timing: accept edge = cycle 0, BUSY cycles 1..DIGITS, FINAL cycle
// DIGITS+1, OUT_VALID from cycle DIGITS+2 (9 for WIDTH=24).
//
// Ports:
//   CLK        in   1        clock, rising edge
//   RST        in   1        synchronous active-high reset
//   IN_VALID   in   1        operand pair valid
//   IN_READY   out  1        block can accept an operand pair
//   MANT_A     in   WIDTH    multiplicand (unsigned)
//   MANT_B     in   WIDTH    multiplier (unsigned, Booth-recoded)
//   OUT_VALID  out  1        PRODUCT is valid
//   OUT_READY  in   1        downstream accepts PRODUCT
//   PRODUCT    out  2*WIDTH  MANT_A * MANT_B
//   PROD_MSB   out  1        PRODUCT[2*WIDTH-1], for downstream normalize
// ---------------------------------------------------------------------------
module booth16_seq_mantissa_mul #(
  parameter int WIDTH = 24
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   MANT_A,
  input  logic [WIDTH-1:0]   MANT_B,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic               PROD_MSB
);

  localparam int DIGITS = (WIDTH + 1 + 3) / 4;
  localparam int ACCW   = 2 * WIDTH + 4;
  localparam int BW     = 4 * DIGITS;
  localparam int PPW    = WIDTH + 4;
  localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [KW-1:0]  K_LAST = KW'(DIGITS - 1);
  localparam logic [KW-1:0]  K_ONE  = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [PPW-1:0] PP_ONE = {{(PPW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Radix-16 Booth encoder + select. Window {b[4k+3:4k], b[4k-1]} has
  // weights -8,4,2,1,1. Returns the two's complement partial product
  // with the +1 of negation already folded in.
  function automatic logic [PPW-1:0] booth16_pp(input logic [4:0]       win,
                                                input logic [WIDTH-1:0] a);
    logic [5:0]     digit;
    logic           neg;
    logic [3:0]     mag;
    logic [PPW-1:0] ax;
    logic [PPW-1:0] mult;
    digit = {3'b000, win[3:1]} + {5'b00000, win[0]} - {2'b00, win[4], 3'b000};
    neg   = digit[5];
    mag   = 4'(neg ? (6'b000000 - digit) : digit);
    ax    = {4'b0000, a};
    case (mag)
      4'd0:    mult = {PPW{1'b0}};
      4'd1:    mult = ax;
      4'd2:    mult = ax << 1;
      4'd3:    mult = ax + (ax << 1);
      4'd4:    mult = ax << 2;
      4'd5:    mult = ax + (ax << 2);
      4'd6:    mult = (ax << 1) + (ax << 2);
      4'd7:    mult = (ax << 3) - ax;   // hard multiple, 8A - A
      4'd8:    mult = ax << 3;
      default: mult = {PPW{1'b0}};
    endcase
    return neg ? (~mult + PP_ONE) : mult;
  endfunction

  // 3:2 carry-save compressor; returns {sum, carry}, carry already shifted
  // left by one with plus_one injected at bit 0.
  function automatic logic [2*ACCW-1:0] csa32(input logic [ACCW-1:0] x,
                                              input logic [ACCW-1:0] y,
                                              input logic [ACCW-1:0] z,
                                              input logic            plus_one);
    logic [ACCW-1:0] s;
    logic [ACCW-1:0] c;
    s = x ^ y ^ z;
    c = (((x & y) | (x & z) | (y & z)) << 1) | {{(ACCW-1){1'b0}}, plus_one};
    return {s, c};
  endfunction

  state_t               state_r;
  state_t               state_next_s;
  logic [WIDTH-1:0]     a_r;
  logic [BW-1:0]        b_r;
  logic [ACCW-1:0]      sum_r;
  logic [ACCW-1:0]      carry_r;
  logic [KW-1:0]        k_r;
  logic [2*WIDTH-1:0]   product_r;
  logic                 prod_msb_r;
  logic                 out_valid_r;

  logic                 in_ready_s;
  logic                 accept_s;
  logic [KW+1:0]        bit_base_s;
  logic [BW:0]          b_ext_s;
  logic [4:0]           win_s;
  logic [PPW-1:0]       pp_s;
  logic [ACCW-1:0]      pp_acc_s;
  logic [2*ACCW-1:0]    csa_s;
  logic [2*WIDTH-1:0]   final_s;

  // Digit k starts at bit 4k; the appended zero supplies b[-1] for k=0.
  assign bit_base_s = {k_r, 2'b00};
  assign b_ext_s    = {b_r, 1'b0};
  assign win_s      = 5'(b_ext_s >> bit_base_s);
  assign pp_s       = booth16_pp(win_s, a_r);
  assign pp_acc_s   = {{(ACCW-PPW){pp_s[PPW-1]}}, pp_s} << bit_base_s;
  assign csa_s      = csa32(sum_r, carry_r, pp_acc_s, 1'b0);
  // Product fits in 2*WIDTH bits, so the resolving add is done mod 2^(2*WIDTH).
  assign final_s    = sum_r[2*WIDTH-1:0] + carry_r[2*WIDTH-1:0];

  // Next-state and handshake decode.
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (IN_VALID) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (k_r == K_LAST) begin
          state_next_s = FINAL;
        end else begin
          state_next_s = BUSY;
        end
      end
      FINAL: begin
        state_next_s = DONE;
      end
      DONE: begin
        // Consuming the result frees the slot in the same cycle.
        if (OUT_READY) begin
          in_ready_s = 1'b1;
          if (IN_VALID) begin
            state_next_s = BUSY;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          in_ready_s   = 1'b0;
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    accept_s = in_ready_s & IN_VALID;
  end

  // State register and output-valid flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s == DONE);
    end
  end

  // Operand capture, digit iteration and carry-save accumulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {BW{1'b0}};
      sum_r   <= {ACCW{1'b0}};
      carry_r <= {ACCW{1'b0}};
      k_r     <= {KW{1'b0}};
    end else if (accept_s) begin
      a_r     <= MANT_A;
      b_r     <= {{(BW-WIDTH){1'b0}}, MANT_B};
      sum_r   <= {ACCW{1'b0}};
      carry_r <= {ACCW{1'b0}};
      k_r     <= {KW{1'b0}};
    end else if (state_r == BUSY) begin
      sum_r   <= csa_s[2*ACCW-1:ACCW];
      carry_r <= csa_s[ACCW-1:0];
      if (k_r != K_LAST) begin
        k_r <= k_r + K_ONE;
      end
    end
  end

  // Result register: written once in FINAL, held through DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      product_r  <= {(2*WIDTH){1'b0}};
      prod_msb_r <= 1'b0;
    end else if (state_r == FINAL) begin
      product_r  <= final_s;
      prod_msb_r <= final_s[2*WIDTH-1];
    end
  end

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = out_valid_r;
  assign PRODUCT   = product_r;
  assign PROD_MSB  = prod_msb_r;

endmodule

// File: tb/tb_booth16_seq_mantissa_mul.sv
// ---------------------------------------------------------------------------
// Testbench for booth16_seq_mantissa_mul: directed vector table, hand-written
// backpressure and reset sequences, then a random run against an A*B model.
// Inputs are driven and outputs sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_booth16_seq_mantissa_mul;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [23:0] MANT_A;
  logic [23:0] MANT_B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [47:0] PRODUCT;
  logic        PROD_MSB;

  int n_pass  = 0;
  int n_total = 0;

  booth16_seq_mantissa_mul #(.WIDTH(24)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .MANT_A    (MANT_A),
    .MANT_B    (MANT_B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .PRODUCT   (PRODUCT),
    .PROD_MSB  (PROD_MSB)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with the block idle. Returns the result and
  // the index of the rising edge (after accept) at which downstream takes it.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        output logic [47:0] p, output logic m, output int lat);
    MANT_A    = a;
    MANT_B    = b;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    MANT_A   = 24'h5A5A5A;
    MANT_B   = 24'hA5A5A5;
    check("accepted_busy_in_ready", IN_READY, 1'b0);
    lat = 0;
    while (!OUT_VALID && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    p   = PRODUCT;
    m   = PROD_MSB;
    lat = lat + 1;
    @(negedge CLK);
    check("out_valid_drops", OUT_VALID, 1'b0);
  endtask

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] prod;
    logic        msb;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [47:0] p;
    logic        m;
    int          lat;
    int          cnt;
    logic [47:0] exp_q[$];
    logic [47:0] e;
    int          sent;
    int          got;
    int          cycles;

    vecs[0]  = '{24'h000001, 24'h000001, 48'h000000000001, 1'b0};
    vecs[1]  = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1};
    vecs[2]  = '{24'h123456, 24'h000007, 48'h0000007F6E5A, 1'b0};
    vecs[3]  = '{24'h800000, 24'h800000, 48'h400000000000, 1'b0};
    vecs[4]  = '{24'hC00000, 24'hC00000, 48'h900000000000, 1'b1};
    vecs[5]  = '{24'h000000, 24'hABCDEF, 48'h000000000000, 1'b0};
    vecs[6]  = '{24'hABCDEF, 24'h000000, 48'h000000000000, 1'b0};
    vecs[7]  = '{24'h000008, 24'h000009, 48'h000000000048, 1'b0};
    vecs[8]  = '{24'hFFFFFF, 24'h000001, 48'h000000FFFFFF, 1'b0};
    vecs[9]  = '{24'h000100, 24'h000100, 48'h000000010000, 1'b0};
    vecs[10] = '{24'h000003, 24'h000005, 48'h00000000000F, 1'b0};
    vecs[11] = '{24'h000011, 24'h000088, 48'h000000000908, 1'b0};
    vecs[12] = '{24'hFFFFFF, 24'h800000, 48'h7FFFFF800000, 1'b0};

    // Reset with IN_VALID high: nothing may be accepted.
    RST       = 1'b1;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b0;
    MANT_A    = 24'h000005;
    MANT_B    = 24'h000005;
    repeat (3) @(negedge CLK);
    RST      = 1'b0;
    IN_VALID = 1'b0;
    #1;
    check("reset_in_ready", IN_READY, 1'b1);
    check("reset_out_valid", OUT_VALID, 1'b0);
    check("reset_product", PRODUCT, 48'h0);
    check("reset_prod_msb", PROD_MSB, 1'b0);
    @(negedge CLK);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, p, m, lat);
      check($sformatf("vec%0d_product", i), p, vecs[i].prod);
      check($sformatf("vec%0d_msb", i), m, vecs[i].msb);
      check($sformatf("vec%0d_latency", i), lat, 9);
    end

    // Backpressure: result held for 5 cycles, new operand refused, then
    // accepted on the same edge the result is consumed.
    MANT_A    = 24'h00ABCD;
    MANT_B    = 24'h000123;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b0;
    @(negedge CLK);
    IN_VALID = 1'b0;
    cnt = 0;
    while (!OUT_VALID && cnt < 30) begin
      @(negedge CLK);
      cnt++;
    end
    check("bp_result_arrives", OUT_VALID, 1'b1);
    IN_VALID = 1'b1;
    MANT_A   = 24'h000002;
    MANT_B   = 24'h000003;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_hold%0d_product", i), PRODUCT, 48'h000000C34A07);
      check($sformatf("bp_hold%0d_in_ready", i), IN_READY, 1'b0);
      check($sformatf("bp_hold%0d_out_valid", i), OUT_VALID, 1'b1);
      @(negedge CLK);
    end
    OUT_READY = 1'b1;
    #1;
    check("bp_release_in_ready", IN_READY, 1'b1);
    @(negedge CLK);
    IN_VALID = 1'b0;
    MANT_A   = 24'hFFFFFF;
    MANT_B   = 24'hFFFFFF;
    check("bp_b2b_out_valid_drop", OUT_VALID, 1'b0);
    check("bp_b2b_busy", IN_READY, 1'b0);
    lat = 0;
    while (!OUT_VALID && lat < 30) begin
      @(negedge CLK);
      lat++;
    end
    check("bp_b2b_latency", lat + 1, 9);
    check("bp_b2b_product", PRODUCT, 48'h6);
    @(negedge CLK);

    // Reset at cycle 4 of an operation discards it.
    MANT_A    = 24'h654321;
    MANT_B    = 24'h00FFFF;
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    RST      = 1'b1;
    IN_VALID = 1'b1;
    @(negedge CLK);
    RST      = 1'b0;
    IN_VALID = 1'b0;
    #1;
    check("midrst_in_ready", IN_READY, 1'b1);
    check("midrst_out_valid", OUT_VALID, 1'b0);
    check("midrst_product", PRODUCT, 48'h0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (OUT_VALID) cnt++;
    end
    check("midrst_no_stale_valid", cnt, 0);
    run_op(24'h000003, 24'h000005, p, m, lat);
    check("midrst_next_product", p, 48'h00000000000F);
    check("midrst_next_latency", lat, 9);

    // Random operands with random gaps and backpressure.
    sent   = 0;
    got    = 0;
    cycles = 0;
    while ((sent < 2000 || exp_q.size() > 0) && cycles < 60000) begin
      IN_VALID  = (sent < 2000) && ($urandom_range(0, 3) != 0);
      MANT_A    = 24'($urandom);
      MANT_B    = 24'($urandom);
      OUT_READY = ($urandom_range(0, 3) != 0);
      #1;
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rand_unexpected_result: got 0x%0h, expected no result", PRODUCT);
        end else begin
          e = exp_q.pop_front();
          check("rand_product", PRODUCT, e);
          check("rand_msb", PROD_MSB, e[47]);
          got++;
        end
      end
      if (IN_VALID && IN_READY) begin
        exp_q.push_back(48'(MANT_A) * 48'(MANT_B));
        sent++;
      end
      @(negedge CLK);
      cycles++;
    end
    IN_VALID = 1'b0;
    check("rand_results_count", got, 2000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
